// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first framing.
// Define UART_RX_PARITY_EN to add one parity bit (even, or odd with PARITY_ODD=1).
module uart_rx #(
   parameter int BAUD_DIV   = 5208,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] dat,
   output logic                 dat_valid,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic                 sync1_q;
   logic                 rxs_q;
   logic                 rxs_prev_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 brk_q, brk_d;
   logic                 done_q, done_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] dat_q, dat_d;
   logic                 dat_valid_q, dat_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 full_tick;

`ifdef UART_RX_PARITY_EN
   localparam logic ODD = (PARITY_ODD != 0);
   logic par_bad_q, par_bad_d;
   logic parity_err_q, parity_err_d;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   assign full_tick = (cnt_q == FULL_M1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = full_tick ? '0 : cnt_q + 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      brk_d       = brk_q;
      done_d      = 1'b0;
      stop_d      = stop_q;
      dat_d       = dat_q;
      dat_valid_d = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif

      if (rxs_q) begin
         brk_d = 1'b0;
      end

      // Result of the stop-bit sample is reported one cycle later
      if (done_q) begin
         if (!stop_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
         end else if (par_bad_q) begin
            parity_err_d = 1'b1;
`endif
         end else begin
            dat_d       = shift_q;
            dat_valid_d = 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs_q && rxs_prev_q && !brk_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rxs_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (full_tick) begin
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (full_tick) begin
               par_bad_d = rxs_q != (^shift_q ^ ODD);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (full_tick) begin
               done_d  = 1'b1;
               stop_d  = rxs_q;
               state_d = S_IDLE;
               // A low stop bit may be a break: wait for idle
               if (!rxs_q) begin
                  brk_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         rxs_prev_q  <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         brk_q       <= 1'b0;
         done_q      <= 1'b0;
         stop_q      <= 1'b1;
         dat_q       <= '0;
         dat_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= rx;
         rxs_q       <= sync1_q;
         rxs_prev_q  <= rxs_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         brk_q       <= brk_d;
         done_q      <= done_d;
         stop_q      <= stop_d;
         dat_q       <= dat_d;
         dat_valid_q <= dat_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign dat       = dat_q;
   assign dat_valid = dat_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx (BAUD_DIV=16, DATA_BITS=8).
// Frames are modelled as line-level bit sequences; a monitor checks pulses.
module tb_uart_rx;

   localparam int B = 16;
   localparam int N = 8;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   // rx change to pulse: 2 sync flops + edge detect, half bit, rest of frame, output reg
   localparam int LAT = 3 + B / 2 + (N + 1 + P) * B + 1;

   localparam int K_OK = 0;
   localparam int K_FE = 1;
   localparam int K_PE = 2;

   typedef struct {
      int         kind;
      logic [7:0] d;
      int         at;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] dat;
   logic       dv, fe, pe;

   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] last_good = 8'h00;
   ev_t        exp_q[$];

   uart_rx #(
      .BAUD_DIV(B),
      .DATA_BITS(N),
      .PARITY_ODD(0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx(rx),
      .dat(dat),
      .dat_valid(dv),
      .frame_err(fe),
      .parity_err(pe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // Model the outcome of one frame, then drive it on the line
   task automatic send(input logic [7:0] d, input bit stop_ok,
                       input bit par_ok, input int gap);
      ev_t  e;
      logic pbit;
      pbit = ^d;
      if (!par_ok) pbit = ~pbit;
      e.at = cyc + LAT;
      if (!stop_ok) begin
         e.kind = K_FE;
         e.d    = last_good;
      end else if (P == 1 && !par_ok) begin
         e.kind = K_PE;
         e.d    = last_good;
      end else begin
         e.kind    = K_OK;
         e.d       = d;
         last_good = d;
      end
      exp_q.push_back(e);
      rx = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         rx = d[i];
         repeat (B) @(negedge clk);
      end
      if (P == 1) begin
         rx = pbit;
         repeat (B) @(negedge clk);
      end
      rx = stop_ok;
      repeat (B) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   always @(negedge clk) begin
      ev_t e;
      int  k;
      if (rst_n && (dv || fe || pe)) begin
         chk("one_hot", int'(dv) + int'(fe) + int'(pe), 1);
         k = dv ? K_OK : (fe ? K_FE : K_PE);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: got kind %0d dat 0x%0h want none at cycle %0d",
                     k, dat, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("kind", k, e.kind);
            chk("dat", int'(dat), int'(e.d));
            chk("time", cyc, e.at);
         end
      end
   end

   initial begin
      logic [7:0] d;
      bit         s_ok, p_ok;
      int         gap, w;

      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dat", int'(dat), 0);
      chk("rst_dv", int'(dv), 0);
      chk("rst_fe", int'(fe), 0);
      chk("rst_pe", int'(pe), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      send(8'hA5, 1, 1, 20);

      // Short low glitch must be rejected silently
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      send(8'h5A, 1, 1, 20);

      send(8'hA5, 1, 1, 5);
      send(8'h3C, 0, 1, B);

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1, 0, 10);
      send(8'h07, 1, 1, 10);
`endif

      send(8'h00, 1, 1, 0);
      send(8'hFF, 1, 1, 20);

      // Reset in the middle of data bit 3
      rx = 1'b0;
      repeat (B) @(negedge clk);
      d = 8'h6B;
      for (int i = 0; i < 3; i++) begin
         rx = d[i];
         repeat (B) @(negedge clk);
      end
      rx = d[3];
      repeat (B / 2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      rx    = 1'b1;
      #1;
      chk("mid_rst_dat", int'(dat), 0);
      chk("mid_rst_dv", int'(dv), 0);
      chk("mid_rst_fe", int'(fe), 0);
      chk("mid_rst_pe", int'(pe), 0);
      repeat (3) @(negedge clk);
      rst_n     = 1'b1;
      last_good = 8'h00;
      repeat (20) @(negedge clk);
      send(8'h81, 1, 1, 20);

      for (int n = 0; n < 25; n++) begin
         d    = 8'($urandom);
         s_ok = ($urandom_range(0, 5) != 0);
         p_ok = ($urandom_range(0, 4) != 0);
         gap  = s_ok ? int'($urandom_range(0, 12)) : B + int'($urandom_range(0, 8));
         send(d, s_ok, p_ok, gap);
      end

      w = 0;
      while (exp_q.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (20) @(negedge clk);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
